rx_comma_aligner: RTL and testbench

- Serial-to-parallel receive front end that sits directly upstream of the 10-bit decoder.
- Shifts in the recovered serial 8b/10b bit stream and hunts for the K28.5 comma to find the symbol boundary.
- Verifies alignment over consecutive commas, then delivers aligned 10-bit symbols with a valid strobe and a lock flag.
- Bit order matches the encoder: bit "a" is transmitted first and lands in oData[9]; bit "j" lands in oData[0].

---
 rtl/rx_comma_aligner_if.sv | 22 ++
 rtl/rx_comma_aligner.sv | 174 +++++++++++++++++
 tb/tb_rx_comma_aligner.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rx_comma_aligner_if.sv
// Receive-side bus of the comma aligner: serial bits in, aligned symbols out.
interface rx_comma_aligner_if;
  logic       iBit;
  logic       iValid;
  logic [9:0] oData;
  logic       oValid;
  logic       COMMA;
  logic       LOCKED;
  logic       ALIGN_EVENT;

  // Upstream side: drives the recovered bit stream, observes aligned symbols.
  modport master (
    output iBit, iValid,
    input  oData, oValid, COMMA, LOCKED, ALIGN_EVENT
  );

  // Aligner side.
  modport slave (
    input  iBit, iValid,
    output oData, oValid, COMMA, LOCKED, ALIGN_EVENT
  );
endinterface

// File: rtl/rx_comma_aligner.sv
// Serial-to-parallel 8b/10b front end: hunts for K28.5, verifies the symbol
// boundary over consecutive commas, then emits aligned 10-bit symbols.
// Bit "a" arrives first and ends up in oData[9].
module rx_comma_aligner #(
  parameter int unsigned LOCK_COMMAS = 3,  // aligned commas needed to lock (1..15)
  parameter int unsigned LOSS_COMMAS = 4   // misaligned commas that drop lock (1..15)
) (
  input  logic               INTERCLK,
  input  logic               Reset,
  rx_comma_aligner_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [3:0] LOCK_TGT  = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_TGT  = 4'(LOSS_COMMAS);

  state_t      state_q, state_d;
  // Only the nine older bits are stored; the tenth is the bit arriving now.
  logic [8:0]  sh_q, sh_d;
  logic [3:0]  ph_q, ph_d;
  logic [3:0]  ccnt_q, ccnt_d;
  logic [3:0]  ecnt_q, ecnt_d;
  logic [9:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        comma_q, comma_d;
  logic        align_q, align_d;
  logic        locked_q, locked_d;

  logic [9:0]  sh_next;
  logic        is_comma;
  logic        boundary;
  logic [3:0]  ph_adv;
  logic [3:0]  ccnt_inc;
  logic [3:0]  ecnt_inc;

  // Window as it will look after this bit, and the per-bit event decode.
  always_comb begin
    sh_next  = {sh_q, bus.iBit};
    is_comma = (sh_next == K28_5_RDN) || (sh_next == K28_5_RDP);
    boundary = (ph_q == 4'd9);
    ph_adv   = boundary ? 4'd0 : ph_q + 4'd1;
    ccnt_inc = (ccnt_q == 4'hF) ? 4'hF : ccnt_q + 4'd1;
    ecnt_inc = (ecnt_q == 4'hF) ? 4'hF : ecnt_q + 4'd1;
  end

  // Alignment FSM: next state, counters and the symbol/strobe outputs.
  always_comb begin
    // NOTE: every target gets a default before any branch so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sh_d    = sh_q;
    ph_d    = ph_q;
    ccnt_d  = ccnt_q;
    ecnt_d  = ecnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    comma_d = 1'b0;
    align_d = 1'b0;

    if (bus.iValid) begin
      sh_d = sh_next[8:0];
      ph_d = ph_adv;

      case (state_q)
        ST_HUNT: begin
          if (is_comma) begin
            data_d  = sh_next;
            valid_d = 1'b1;
            comma_d = 1'b1;
            align_d = 1'b1;
            ph_d    = 4'd0;
            ccnt_d  = 4'd1;
            ecnt_d  = 4'd0;
            state_d = (LOCK_TGT <= 4'd1) ? ST_LOCKED : ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          if (boundary) begin
            // A comma landing on the boundary counts as aligned.
            data_d  = sh_next;
            valid_d = 1'b1;
            comma_d = is_comma;
            if (is_comma) begin
              ccnt_d = ccnt_inc;
              if (ccnt_inc >= LOCK_TGT) begin
                state_d = ST_LOCKED;
                ecnt_d  = 4'd0;
              end
            end
          end else if (is_comma) begin
            // Boundary was wrong: restart verification on this comma.
            data_d  = sh_next;
            valid_d = 1'b1;
            comma_d = 1'b1;
            align_d = 1'b1;
            ph_d    = 4'd0;
            ccnt_d  = 4'd1;
          end
        end

        ST_LOCKED: begin
          if (boundary) begin
            data_d  = sh_next;
            valid_d = 1'b1;
            comma_d = is_comma;
            if (is_comma) begin
              ecnt_d = 4'd0;
            end
          end else if (is_comma) begin
            // Misaligned commas are tolerated until the loss threshold; the
            // one that crosses it is dropped and the next comma is hunted.
            if (ecnt_inc >= LOSS_TGT) begin
              state_d = ST_HUNT;
              ecnt_d  = 4'd0;
              ccnt_d  = 4'd0;
            end else begin
              ecnt_d = ecnt_inc;
            end
          end
        end

        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge INTERCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      state_q  <= ST_HUNT;
      sh_q     <= '0;
      ph_q     <= '0;
      ccnt_q   <= '0;
      ecnt_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      comma_q  <= 1'b0;
      align_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      ph_q     <= ph_d;
      ccnt_q   <= ccnt_d;
      ecnt_q   <= ecnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      comma_q  <= comma_d;
      align_q  <= align_d;
      locked_q <= locked_d;
    end
  end

  assign bus.oData       = data_q;
  assign bus.oValid      = valid_q;
  assign bus.COMMA       = comma_q;
  assign bus.LOCKED      = locked_q;
  assign bus.ALIGN_EVENT = align_q;

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Directed bench for rx_comma_aligner: reset, acquisition, data, gaps,
// slip/relock and mid-lock reset, with hand-computed expectations.
module tb_rx_comma_aligner;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;
  localparam logic [9:0] D21_5 = 10'b1010101010;

  logic interclk = 1'b0;
  logic reset_n;

  rx_comma_aligner_if bus ();

  rx_comma_aligner #(
    .LOCK_COMMAS (3),
    .LOSS_COMMAS (4)
  ) dut (
    .INTERCLK (interclk),
    .Reset    (reset_n),
    .bus      (bus)
  );

  always #5 interclk = ~interclk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         pulses;
  int         aligns;
  int         last_pulse = 0;
  int         prev_pulse = 0;
  logic [9:0] last_data;
  logic       last_comma;
  logic       v_last;
  logic       lk;
  int         hunt_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit slot at the falling edge, observe 1 time unit after the rising edge.
  task automatic send_bit(input logic b, input logic v);
    @(negedge interclk);
    bus.iBit   = b;
    bus.iValid = v;
    @(posedge interclk);
    #1;
    cyc++;
    if (bus.oValid === 1'b1) begin
      pulses++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      last_data  = bus.oData;
      last_comma = bus.COMMA;
    end
    if (bus.ALIGN_EVENT === 1'b1) aligns++;
  endtask

  task automatic start_sym();
    pulses = 0;
    aligns = 0;
  endtask

  // Send a symbol MSB (bit "a") first, then snapshot the final-bit outputs.
  task automatic send_sym(input logic [9:0] s);
    start_sym();
    for (int i = 9; i >= 0; i--) send_bit(s[i], 1'b1);
    v_last = bus.oValid;
    lk     = bus.LOCKED;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    bus.iBit   = 1'b0;
    bus.iValid = 1'b0;

    // Reset held with live input: every output stays 0.
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom), 1'b1);
      check("rst_outputs",
            32'({bus.oData, bus.oValid, bus.COMMA, bus.LOCKED, bus.ALIGN_EVENT}), 32'd0);
    end
    reset_n = 1'b1;

    // 40 bits of D21.5 in HUNT: nothing emitted.
    hunt_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      send_sym(D21_5);
      hunt_pulses += pulses + aligns;
    end
    check("hunt_no_valid", 32'(hunt_pulses), 32'd0);

    // Three filler bits, then three commas.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);

    send_sym(K_RDN);
    check("c1_valid",  32'(v_last),     32'd1);
    check("c1_data",   32'(last_data),  32'(K_RDN));
    check("c1_comma",  32'(last_comma), 32'd1);
    check("c1_align",  32'(aligns),     32'd1);
    check("c1_locked", 32'(lk),         32'd0);

    send_sym(K_RDP);
    check("c2_valid",  32'(v_last),     32'd1);
    check("c2_data",   32'(last_data),  32'(K_RDP));
    check("c2_comma",  32'(last_comma), 32'd1);
    check("c2_locked", 32'(lk),         32'd0);
    check("c2_align",  32'(aligns),     32'd0);

    send_sym(K_RDN);
    check("c3_valid",  32'(v_last),     32'd1);
    check("c3_locked", 32'(lk),         32'd1);
    check("c3_data",   32'(last_data),  32'(K_RDN));

    // Data after lock: one strobe per 10 bits.
    for (int k = 0; k < 5; k++) begin
      send_sym(D21_5);
      check("dat_valid",    32'(v_last),                  32'd1);
      check("dat_pulses",   32'(pulses),                  32'd1);
      check("dat_data",     32'(last_data),               32'(D21_5));
      check("dat_comma",    32'(last_comma),              32'd0);
      check("dat_locked",   32'(lk),                      32'd1);
      check("dat_interval", 32'(last_pulse - prev_pulse), 32'd10);
    end

    // Gapped symbol: 4 bits, 5 idle slots, 6 bits.
    start_sym();
    for (int i = 9; i >= 6; i--) send_bit(D21_5[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 1'b0);
      check("gap_idle_valid", 32'(bus.oValid), 32'd0);
    end
    for (int i = 5; i >= 0; i--) send_bit(D21_5[i], 1'b1);
    check("gap_valid",    32'(bus.oValid),              32'd1);
    check("gap_data",     32'(last_data),               32'(D21_5));
    check("gap_interval", 32'(last_pulse - prev_pulse), 32'd15);

    // Slip by one bit, then four misaligned commas.
    send_bit(1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      send_sym((k % 2 == 1) ? K_RDN : K_RDP);
      check("slip_locked",     32'(lk),         (k < 4) ? 32'd1 : 32'd0);
      check("slip_valid_last", 32'(v_last),     32'd0);
      check("slip_pulses",     32'(pulses),     32'd1);
      check("slip_comma",      32'(last_comma), 32'd0);
      check("slip_align",      32'(aligns),     32'd0);
    end

    // Fifth comma is hunted on the new boundary.
    send_sym(K_RDN);
    check("c5_valid",  32'(v_last),     32'd1);
    check("c5_pulses", 32'(pulses),     32'd1);
    check("c5_align",  32'(aligns),     32'd1);
    check("c5_comma",  32'(last_comma), 32'd1);
    check("c5_locked", 32'(lk),         32'd0);

    send_sym(K_RDP);
    check("c6_valid",  32'(v_last), 32'd1);
    check("c6_locked", 32'(lk),     32'd0);

    send_sym(K_RDN);
    check("c7_valid",  32'(v_last), 32'd1);
    check("c7_locked", 32'(lk),     32'd1);

    // Reset during a data symbol.
    for (int i = 9; i >= 6; i--) send_bit(D21_5[i], 1'b1);
    reset_n = 1'b0;
    send_bit(1'b1, 1'b1);
    check("rstm_locked", 32'(bus.LOCKED), 32'd0);
    check("rstm_valid",  32'(bus.oValid), 32'd0);
    check("rstm_data",   32'(bus.oData),  32'd0);
    reset_n = 1'b1;

    // Re-acquire from scratch: three fresh commas.
    send_sym(D21_5);
    check("racq_hunt_pulses", 32'(pulses), 32'd0);

    send_sym(K_RDN);
    check("racq1_valid",  32'(v_last), 32'd1);
    check("racq1_align",  32'(aligns), 32'd1);
    check("racq1_locked", 32'(lk),     32'd0);

    send_sym(K_RDP);
    check("racq2_locked", 32'(lk), 32'd0);

    send_sym(K_RDN);
    check("racq3_locked", 32'(lk),        32'd1);
    check("racq3_data",   32'(last_data), 32'(K_RDN));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
